// File: rtl/instruction_sequencer.sv
// Fetch/execute phase controller: sequences instruction reads, pulses the
// instruction-latch load, inserts an optional second execute cycle and
// handles debug halt/step and bus fetch timeout.
module instruction_sequencer #(
    parameter int unsigned RESET_HOLD   = 2,
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               MEM_READY,
    input  logic               MULTI_CYCLE,
    input  logic               HALT_INSN,
    input  logic               DEBUG_MODE,
    input  logic               DEBUG_STEP,
    output logic               MEM_RD,
    output logic               EXECUTE,
    output logic               PC_INC,
    output logic [1:0]         PHASE,
    output logic               HALTED,
    output logic               BUS_ERROR,
    output logic [COUNT_W-1:0] INSN_COUNT
);

    typedef enum logic [3:0] {
        S_HOLD, S_FETCH, S_WAIT, S_LATCH, S_EXEC, S_EXEC2, S_WB, S_HALT, S_ERROR
    } state_t;

    typedef enum logic {
        CAUSE_DEBUG = 1'b0,
        CAUSE_INSN  = 1'b1
    } cause_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT);

    state_t               state, state_nxt;
    cause_t               halt_cause, cause_nxt;
    logic [3:0]           hold_cnt, hold_nxt;
    logic [7:0]           wait_cnt, wait_nxt;
    logic [7:0]           wait_inc;
    logic [COUNT_W-1:0]   insn_count, count_nxt;
    logic                 step_q;
    logic                 step_edge;

    assign step_edge  = DEBUG_STEP & ~step_q;
    assign wait_inc   = wait_cnt + 8'd1;
    assign INSN_COUNT = insn_count;

    // State, counters and step-edge register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_HOLD;
            halt_cause <= CAUSE_DEBUG;
            hold_cnt   <= '0;
            wait_cnt   <= '0;
            insn_count <= '0;
            step_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            halt_cause <= cause_nxt;
            hold_cnt   <= hold_nxt;
            wait_cnt   <= wait_nxt;
            insn_count <= count_nxt;
            step_q     <= DEBUG_STEP;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_nxt = state;
        cause_nxt = halt_cause;
        hold_nxt  = hold_cnt;
        wait_nxt  = wait_cnt;
        count_nxt = insn_count;
        MEM_RD    = 1'b0;
        EXECUTE   = 1'b0;
        PC_INC    = 1'b0;
        PHASE     = 2'd0;
        HALTED    = 1'b0;
        BUS_ERROR = 1'b0;

        case (state)
            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (DEBUG_MODE) begin
                        state_nxt = S_HALT;
                        cause_nxt = CAUSE_DEBUG;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end else begin
                    hold_nxt = hold_cnt + 4'd1;
                end
            end
            S_FETCH: begin
                MEM_RD = 1'b1;
                if (MEM_READY) begin
                    state_nxt = S_LATCH;
                end else if (WAIT_LAST == 8'd1) begin
                    // The first low cycle already reaches a timeout of one
                    state_nxt = S_ERROR;
                    wait_nxt  = 8'd1;
                end else begin
                    state_nxt = S_WAIT;
                    wait_nxt  = 8'd1;
                end
            end
            S_WAIT: begin
                MEM_RD = 1'b1;
                if (MEM_READY) begin
                    state_nxt = S_LATCH;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_inc;
                    if (wait_inc == WAIT_LAST) state_nxt = S_ERROR;
                end
            end
            S_LATCH: begin
                EXECUTE   = 1'b1;
                PC_INC    = 1'b1;
                PHASE     = 2'd1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                PHASE     = 2'd2;
                state_nxt = MULTI_CYCLE ? S_EXEC2 : S_WB;
            end
            S_EXEC2: begin
                PHASE     = 2'd2;
                state_nxt = S_WB;
            end
            S_WB: begin
                PHASE     = 2'd3;
                count_nxt = insn_count + 1'b1;
                if (HALT_INSN) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_INSN;
                end else if (DEBUG_MODE) begin
                    state_nxt = S_HALT;
                    cause_nxt = CAUSE_DEBUG;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                HALTED = 1'b1;
                if (step_edge || (halt_cause == CAUSE_DEBUG && !DEBUG_MODE))
                    state_nxt = S_FETCH;
            end
            S_ERROR: begin
                HALTED    = 1'b1;
                BUS_ERROR = 1'b1;
            end
            default: state_nxt = S_HOLD;
        endcase
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
- Fetch/execute phase controller for the CPU core.
- Sequences memory reads and generates the one-cycle EXECUTE strobe that loads the instruction latch.
- Inserts a second execute cycle for multi-cycle ops and handles halt, single-step and bus timeout.
- Sits between the memory/bus interface, the instruction decoder and the instruction latch; the debug controller drives its halt/step inputs.

Parameters:
- RESET_HOLD, 2, number of cycles held in HOLD after reset release before the first fetch (range 1-15).
- WAIT_TIMEOUT, 15, number of consecutive MEM_READY-low cycles in FETCH/WAIT that raises a bus error (range 1-255).
- COUNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- MEM_READY  in  1  bus has valid instruction word on DIN this cycle.
- MULTI_CYCLE  in  1  decoder: latched instruction needs a second execute cycle; sampled in EXEC.
- HALT_INSN  in  1  decoder: latched instruction is HALT; sampled in WB.
- DEBUG_MODE  in  1  level halt request from the debug controller.
- DEBUG_STEP  in  1  step request; rising edge detected internally.
- MEM_RD  out  1  instruction read request.
- EXECUTE  out  1  instruction-latch load enable; one-cycle pulse.
- PC_INC  out  1  program-counter increment; one-cycle pulse, coincident with EXECUTE.
- PHASE  out  2  0 = fetch/idle, 1 = latch, 2 = execute, 3 = writeback.
- HALTED  out  1  core halted (HALT or ERROR state).
- BUS_ERROR  out  1  sticky fetch-timeout flag.
- INSN_COUNT  out  COUNT_W  retired-instruction count.

Behaviour:
- Reset:
  - RESET_N low immediately forces state HOLD, hold counter 0 and wait counter 0.
  - MEM_RD, EXECUTE, PC_INC, HALTED and BUS_ERROR are forced to 0, PHASE to 0 and INSN_COUNT to 0.
  - The DEBUG_STEP edge register is cleared; halt_cause is cleared to 0.
- Outputs are registered or decoded purely from state; there is no combinational path from any input to any output.
- HOLD: counts RESET_HOLD cycles after reset release, then goes to HALT (halt_cause = debug) if DEBUG_MODE is 1, else to FETCH.
- FETCH:
  - MEM_RD = 1.
  - MEM_READY = 1 goes to LATCH; otherwise goes to WAIT with the wait counter set to 1.
- WAIT:
  - MEM_RD = 1.
  - MEM_READY = 1 goes to LATCH and clears the wait counter.
  - Otherwise the counter increments. When it reaches WAIT_TIMEOUT, the next state is ERROR.
  - MEM_READY arriving on the same cycle the count is reached wins: next state is LATCH.
- LATCH:
  - EXECUTE = 1 and PC_INC = 1 for exactly this cycle; PHASE = 1. Next state is EXEC.
  - The instruction latch captures on the falling edge within this cycle, so decoder outputs are valid from EXEC onward.
- EXEC: PHASE = 2. Next state is EXEC2 if MULTI_CYCLE, else WB.
- EXEC2: PHASE = 2. Next state is WB; MULTI_CYCLE is ignored here, so the maximum is two execute cycles.
- WB:
  - PHASE = 3. INSN_COUNT increments, wrapping from all-ones to 0.
  - HALT_INSN = 1 goes to HALT with halt_cause = insn.
  - Else DEBUG_MODE = 1 goes to HALT with halt_cause = debug.
  - Else goes to FETCH.
- HALT:
  - HALTED = 1; MEM_RD = 0.
  - A DEBUG_STEP rising edge goes to FETCH: exactly one instruction executes, then WB re-enters HALT while DEBUG_MODE is still 1.
  - If halt_cause = debug and DEBUG_MODE = 0, goes to FETCH.
  - If halt_cause = insn, only a DEBUG_STEP edge or reset leaves HALT.
  - Step edge and DEBUG_MODE fall in the same cycle: go to FETCH (resume).
- ERROR: HALTED = 1 and BUS_ERROR = 1; exited only by reset.
- DEBUG_MODE is sampled only in HOLD, WB and HALT, so an in-flight instruction always completes to WB before halting.
- A DEBUG_STEP edge outside HALT is discarded and not queued.
- Reset during WAIT or EXEC aborts with no INSN_COUNT increment.

Test Plan:
- Reset release with MEM_READY tied to 1 and RESET_HOLD = 2 -> first MEM_RD on cycle 3. EXECUTE pulses every 4 cycles. INSN_COUNT = 3 after 12 cycles past the first fetch.
- MEM_READY low for 3 cycles, then high -> WAIT for 3 cycles, a single EXECUTE pulse, BUS_ERROR stays 0.
- MEM_READY held low with WAIT_TIMEOUT = 15 -> ERROR after 15 low cycles; HALTED = 1 and BUS_ERROR = 1 persist until RESET_N falls.
- MULTI_CYCLE = 1 for one instruction -> PHASE sequence 0, 1, 2, 2, 3; the next instruction's PHASE sequence is 0, 1, 2, 3.
- DEBUG_MODE raised mid-EXEC -> instruction reaches WB and INSN_COUNT increments, then HALTED = 1. Two DEBUG_STEP pulses -> INSN_COUNT +2, HALTED returns to 1 each time. DEBUG_MODE = 0 -> free running.
- HALT_INSN at WB -> HALTED. Dropping DEBUG_MODE alone does not resume. A DEBUG_STEP edge resumes; INSN_COUNT wraps 0xFFFF -> 0x0000 correctly.
